// File: rtl/cam_init_pkg.sv
// Shared definitions for the camera SCCB init sequencer: FSM encoding,
// the end-of-table sentinel and the ROM entry field slices.
package cam_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_ROM  = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5,
    ST_NEXT      = 3'd6,
    ST_FINISH    = 3'd7
  } state_e;

  // A table entry of all ones ends that camera's table early.
  localparam logic [23:0] SENTINEL = 24'hFFFFFF;

  // ROM entry layout: {reg_addr[15:0], reg_val[7:0]}
  function automatic logic [15:0] entry_addr(input logic [23:0] e);
    return e[23:8];
  endfunction

  function automatic logic [7:0] entry_val(input logic [23:0] e);
    return e[7:0];
  endfunction

endpackage

// File: rtl/init_timer.sv
// Loadable down-counter shared by the GAP wait and the write timeout.
// expired is high while the count sits at zero.
module init_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/cam_sccb_init_seq.sv
// Walks the external register table once per camera and issues one SCCB
// write per entry, retrying NACKed / timed-out writes.
// Write handshake: wr_req is a one-cycle pulse issued only when wr_busy was
// low; wr_cam_sel/wr_addr/wr_data are held from wr_req until the wr_done
// pulse that ends the transaction; wr_nack is meaningful only with wr_done.
module cam_sccb_init_seq
  import cam_init_pkg::*;
#(
  parameter logic [7:0]  REG_NUM     = 8'd200,
  parameter logic [1:0]  RETRY_MAX   = 2'd3,
  parameter logic [15:0] GAP_CYC     = 16'd500,
  parameter logic [19:0] TIMEOUT_CYC = 20'd500000
) (
  input  logic        clk_50M,
  input  logic        reset_n,
  input  logic        initial_en,
  output logic [7:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic        wr_req,
  output logic        wr_cam_sel,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_busy,
  input  logic        wr_done,
  input  logic        wr_nack,
  output logic [1:0]  cam_done,
  output logic [1:0]  cam_fail,
  output logic        all_done,
  output logic [2:0]  dbg_state
);

  state_e      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic        cam_q, cam_d;
  logic [1:0]  retry_q, retry_d;
  logic        fail_q, fail_d;
  logic        abort_q, abort_d;
  logic [7:0]  rom_addr_q, rom_addr_d;
  logic        wr_req_q, wr_req_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [1:0]  cam_done_q, cam_done_d;
  logic [1:0]  cam_fail_q, cam_fail_d;
  logic        all_done_q, all_done_d;

  logic        tmr_load;
  logic [19:0] tmr_val;
  logic        tmr_zero;
  logic        attempt_end;
  logic        attempt_ok;
  logic        stop_req;

  // wr_done beats a simultaneous timeout because success only looks at wr_done.
  assign attempt_end = wr_done | tmr_zero;
  assign attempt_ok  = wr_done & ~wr_nack;
  assign stop_req    = abort_q | ~initial_en;

  init_timer #(.W(20)) u_timer (
    .clk      (clk_50M),
    .rst_n    (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; an in-flight write always completes before aborting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (initial_en) state_d = ST_FETCH;
      ST_FETCH:     state_d = initial_en ? ST_WAIT_ROM : ST_IDLE;
      ST_WAIT_ROM: begin
        if (!initial_en)           state_d = ST_IDLE;
        else if (rom_data == SENTINEL) state_d = ST_NEXT;
        else                       state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!initial_en)   state_d = ST_IDLE;
        else if (!wr_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (attempt_end) begin
          if (stop_req)                  state_d = ST_IDLE;
          else if (attempt_ok)           state_d = ST_GAP;
          else if (retry_q < RETRY_MAX)  state_d = ST_ISSUE;
          else                           state_d = ST_NEXT;
        end
      end
      ST_GAP: begin
        if (!initial_en) state_d = ST_IDLE;
        else if (tmr_zero)
          state_d = (index_q == REG_NUM - 8'd1) ? ST_NEXT : ST_FETCH;
      end
      ST_NEXT: begin
        if (!initial_en) state_d = ST_IDLE;
        else             state_d = cam_q ? ST_FINISH : ST_FETCH;
      end
      ST_FINISH:    if (!initial_en) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs, driven by the current transition.
  always_comb begin
    index_d    = index_q;
    cam_d      = cam_q;
    retry_d    = retry_q;
    fail_d     = fail_q;
    abort_d    = abort_q;
    rom_addr_d = rom_addr_q;
    wr_req_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cam_done_d = cam_done_q;
    cam_fail_d = cam_fail_q;
    all_done_d = all_done_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    if (state_q == ST_WAIT_ROM && state_d == ST_ISSUE) begin
      wr_addr_d = entry_addr(rom_data);
      wr_data_d = entry_val(rom_data);
    end

    if (state_q == ST_ISSUE && state_d == ST_WAIT_DONE) begin
      wr_req_d = 1'b1;
      tmr_load = 1'b1;
      tmr_val  = TIMEOUT_CYC - 20'd1;
    end

    if (state_q == ST_WAIT_DONE) begin
      if (!initial_en) abort_d = 1'b1;
      if (state_d == ST_GAP) begin
        retry_d  = '0;
        tmr_load = 1'b1;
        tmr_val  = {4'd0, GAP_CYC - 16'd1};
      end else if (state_d == ST_ISSUE) begin
        retry_d = retry_q + 2'd1;
      end else if (state_d == ST_NEXT) begin
        fail_d = 1'b1;
      end
    end

    if (state_q == ST_GAP && state_d == ST_FETCH) index_d = index_q + 8'd1;

    if (state_q == ST_NEXT) begin
      if (fail_q) cam_fail_d[cam_q] = 1'b1;
      else        cam_done_d[cam_q] = 1'b1;
      if (state_d == ST_FETCH) begin
        cam_d   = 1'b1;
        index_d = '0;
        retry_d = '0;
        fail_d  = 1'b0;
      end
      if (state_d == ST_FINISH) all_done_d = 1'b1;
    end

    if (state_d == ST_FETCH) rom_addr_d = index_d;

    // Entering or sitting in IDLE rewinds everything and clears status.
    if (state_d == ST_IDLE) begin
      index_d    = '0;
      cam_d      = 1'b0;
      retry_d    = '0;
      fail_d     = 1'b0;
      abort_d    = 1'b0;
      rom_addr_d = '0;
      cam_done_d = '0;
      cam_fail_d = '0;
      all_done_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      index_q    <= '0;
      cam_q      <= 1'b0;
      retry_q    <= '0;
      fail_q     <= 1'b0;
      abort_q    <= 1'b0;
      rom_addr_q <= '0;
      wr_req_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cam_done_q <= '0;
      cam_fail_q <= '0;
      all_done_q <= 1'b0;
    end else begin
      index_q    <= index_d;
      cam_q      <= cam_d;
      retry_q    <= retry_d;
      fail_q     <= fail_d;
      abort_q    <= abort_d;
      rom_addr_q <= rom_addr_d;
      wr_req_q   <= wr_req_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cam_done_q <= cam_done_d;
      cam_fail_q <= cam_fail_d;
      all_done_q <= all_done_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign wr_req     = wr_req_q;
  assign wr_cam_sel = cam_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cam_done   = cam_done_q;
  assign cam_fail   = cam_fail_q;
  assign all_done   = all_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cam_sccb_init_seq.sv
// Bench for cam_sccb_init_seq: ROM model, SCCB master model with scripted
// NACK / withheld-done faults, scoreboard of expected writes and a monitor.
module tb_cam_sccb_init_seq;
  import cam_init_pkg::*;

  localparam int TMO = 40;

  // ---------------- clock / reset ----------------
  logic        clk_50M = 1'b0;
  logic        reset_n = 1'b0;
  logic        initial_en = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic        wr_req, wr_cam_sel;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_busy = 1'b0, wr_done = 1'b0, wr_nack = 1'b0;
  logic [1:0]  cam_done, cam_fail;
  logic        all_done;
  logic [2:0]  dbg_state;

  always #5 clk_50M = ~clk_50M;

  cam_sccb_init_seq #(
    .REG_NUM(8'd4), .RETRY_MAX(2'd3), .GAP_CYC(16'd4), .TIMEOUT_CYC(20'd40)
  ) dut (
    .clk_50M(clk_50M), .reset_n(reset_n), .initial_en(initial_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_req(wr_req), .wr_cam_sel(wr_cam_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_nack(wr_nack),
    .cam_done(cam_done), .cam_fail(cam_fail), .all_done(all_done),
    .dbg_state(dbg_state)
  );

  // ---------------- ROM model (1-cycle latency) ----------------
  logic [23:0] tbl [0:255];
  always @(posedge clk_50M) rom_data <= tbl[rom_addr];

  // ---------------- scoreboard state ----------------
  logic [24:0] exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          req_cnt = 0;
  int          last_req_cyc = 0;
  int          req_interval = 0;
  logic [24:0] last_word = '0;
  logic        prev_req = 1'b0;

  logic        fault_cam = 1'b0;
  logic [15:0] fault_addr = '0;
  int          fault_left = 0;
  int          fault_kind = 0;  // 0 = NACK, 1 = withhold wr_done

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic logic [24:0] ent(input logic cam, input int idx);
    return {cam, tbl[idx]};
  endfunction

  task automatic push_cam(input logic cam, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ent(cam, i));
  endtask

  // ---------------- SCCB master model ----------------
  initial begin
    logic do_fault;
    forever begin
      @(negedge clk_50M);
      if (reset_n && wr_req) begin
        do_fault = (fault_left > 0) && (wr_cam_sel == fault_cam) && (wr_addr == fault_addr);
        if (do_fault) fault_left--;
        #1 wr_busy = 1'b1;
        repeat (2) @(negedge clk_50M);
        if (do_fault && fault_kind == 1) begin
          #1 wr_busy = 1'b0;
        end else begin
          #1 wr_done = 1'b1;
          wr_nack = do_fault;
          @(negedge clk_50M);
          #1 wr_done = 1'b0;
          wr_nack = 1'b0;
          wr_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [24:0] word;
    forever begin
      @(negedge clk_50M);
      cyc++;
      if (!reset_n) begin
        prev_req = 1'b0;
      end else begin
        word = {wr_cam_sel, wr_addr, wr_data};
        if (wr_req) begin
          check("req_back_to_back", {31'd0, prev_req}, 32'd0);
          check("req_while_busy", {31'd0, wr_busy}, 32'd0);
          req_interval = cyc - last_req_cyc;
          last_req_cyc = cyc;
          req_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_req: got 0x%0h expected no write (t=%0t)", word, $time);
          end else begin
            check("write_word", {7'd0, word}, {7'd0, exp_q.pop_front()});
          end
          last_word = word;
        end
        if (wr_done) check("held_until_done", {7'd0, word}, {7'd0, last_word});
        prev_req = wr_req;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_all_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50M);
      if (all_done) break;
    end
    check({tag, "_all_done"}, {31'd0, all_done}, 32'd1);
  endtask

  task automatic finish_run(input string tag, input logic [1:0] exp_done, input logic [1:0] exp_fail);
    wait_all_done(tag);
    check({tag, "_cam_done"}, {30'd0, cam_done}, {30'd0, exp_done});
    check({tag, "_cam_fail"}, {30'd0, cam_fail}, {30'd0, exp_fail});
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    initial_en = 1'b0;
    repeat (3) @(negedge clk_50M);
    check({tag, "_status_clear"}, {27'd0, cam_done, cam_fail, all_done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int base;
    for (int i = 0; i < 256; i++) tbl[i] = 24'h0;
    tbl[0] = 24'h3008_12;
    tbl[1] = 24'h3103_A5;
    tbl[2] = 24'h4300_3C;
    tbl[3] = 24'h5A7F_01;

    repeat (3) @(negedge clk_50M);
    check("reset_outputs", {rom_addr, wr_req, wr_cam_sel, wr_data, cam_done, cam_fail, all_done},
          32'd0);
    check("reset_wr_addr", {16'd0, wr_addr}, 32'd0);
    check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    reset_n = 1'b1;
    repeat (2) @(negedge clk_50M);

    // 1) clean run, both cameras
    push_cam(1'b0, 4);
    push_cam(1'b1, 4);
    initial_en = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50M);
      lat++;
      if (wr_req) break;
    end
    check("first_req_latency", lat, 32'd4);
    finish_run("clean", 2'b11, 2'b00);

    // 2) camera1 entry 2 NACKed twice, then accepted
    fault_cam = 1'b0; fault_addr = tbl[2][23:8]; fault_kind = 0; fault_left = 2;
    push_cam(1'b0, 2);
    repeat (3) exp_q.push_back(ent(1'b0, 2));
    exp_q.push_back(ent(1'b0, 3));
    push_cam(1'b1, 4);
    initial_en = 1'b1;
    finish_run("nack_retry", 2'b11, 2'b00);
    check("nack_retry_faults_used", fault_left, 32'd0);

    // 3) camera2 entry 1 NACKed four times -> camera2 fails
    fault_cam = 1'b1; fault_addr = tbl[1][23:8]; fault_kind = 0; fault_left = 4;
    push_cam(1'b0, 4);
    exp_q.push_back(ent(1'b1, 0));
    repeat (4) exp_q.push_back(ent(1'b1, 1));
    initial_en = 1'b1;
    finish_run("nack_fail", 2'b01, 2'b10);

    // 4) camera1 entry 0 never completes -> timeout retries, camera1 fails
    fault_cam = 1'b0; fault_addr = tbl[0][23:8]; fault_kind = 1; fault_left = 4;
    repeat (4) exp_q.push_back(ent(1'b0, 0));
    push_cam(1'b1, 4);
    base = req_cnt;
    initial_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_50M);
      if (req_cnt >= base + 4) break;
    end
    check("timeout_attempts_seen", req_cnt - base, 32'd4);
    check("timeout_interval", {31'd0, (req_interval >= TMO) && (req_interval <= TMO + 2)}, 32'd1);
    finish_run("timeout", 2'b10, 2'b01);
    fault_left = 0;

    // 5) sentinel at entry 1 ends each table after one write
    tbl[1] = SENTINEL;
    exp_q.push_back(ent(1'b0, 0));
    exp_q.push_back(ent(1'b1, 0));
    initial_en = 1'b1;
    finish_run("sentinel", 2'b11, 2'b00);
    tbl[1] = 24'h3103_A5;

    // 6) initial_en dropped while the first write is in flight
    exp_q.push_back(ent(1'b0, 0));
    base = req_cnt;
    initial_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50M);
      if (wr_req) break;
    end
    initial_en = 1'b0;
    repeat (30) @(negedge clk_50M);
    check("abort_single_write", req_cnt - base, 32'd1);
    check("abort_state_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("abort_status_clear", {27'd0, cam_done, cam_fail, all_done}, 32'd0);
    push_cam(1'b0, 4);
    push_cam(1'b1, 4);
    initial_en = 1'b1;
    finish_run("restart", 2'b11, 2'b00);

    // 7) asynchronous reset in the middle of camera2's first GAP
    push_cam(1'b0, 4);
    push_cam(1'b1, 4);
    initial_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_50M);
      if (wr_cam_sel && dbg_state == 3'(ST_GAP)) break;
    end
    check("pre_reset_cam_done", {30'd0, cam_done}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {rom_addr, wr_req, wr_cam_sel, wr_data, cam_done, cam_fail, all_done},
          32'd0);
    check("async_reset_wr_addr", {16'd0, wr_addr}, 32'd0);
    exp_q.delete();
    initial_en = 1'b0;
    @(negedge clk_50M);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_50M);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
